// File: rtl/cmd_reg_responder_if.sv
// Command bus between the HCP configuration master and one cmd_reg_responder.
// Carries write/read command words, read acknowledgements, register taps and the error pulse.
interface cmd_reg_responder_if #(
    parameter int ADDR_WIDTH = 4
);
    localparam int NUM_REGS = (1 << ADDR_WIDTH) - 1;

    logic [203:0]            iv_wr_command;
    logic                    i_wr_command_wr;
    logic [203:0]            iv_rd_command;
    logic                    i_rd_command_wr;
    logic [203:0]            ov_rd_command_ack;
    logic                    o_rd_command_ack_wr;
    logic [32*NUM_REGS-1:0]  ov_cfg_regs;
    logic                    o_cmd_err;

    modport master (
        output iv_wr_command, i_wr_command_wr, iv_rd_command, i_rd_command_wr,
        input  ov_rd_command_ack, o_rd_command_ack_wr, ov_cfg_regs, o_cmd_err
    );

    modport slave (
        input  iv_wr_command, i_wr_command_wr, iv_rd_command, i_rd_command_wr,
        output ov_rd_command_ack, o_rd_command_ack_wr, ov_cfg_regs, o_cmd_err
    );
endinterface

// File: rtl/cmd_reg_responder.sv
// Target-side responder for HCP configuration commands: a bank of 32-bit registers,
// a 2-cycle read-ack pipeline and a saturating access-error counter at the top address.
module cmd_reg_responder #(
    parameter logic [7:0]  MODULE_ID  = 8'd0,
    parameter int          ADDR_WIDTH = 4,
    parameter logic [31:0] RST_VAL    = 32'd0
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    cmd_reg_responder_if.slave   bus
);
    localparam int NUM_REGS = (1 << ADDR_WIDTH) - 1;
    localparam logic [ADDR_WIDTH-1:0] ERR_ADDR = {ADDR_WIDTH{1'b1}};
    localparam logic [3:0] TYPE_WR  = 4'h1;
    localparam logic [3:0] TYPE_RD  = 4'h2;
    localparam logic [3:0] TYPE_ACK = 4'h3;

    function automatic logic [15:0] sat_add(input logic [15:0] cnt, input logic [1:0] inc);
        logic [16:0] sum;
        sum = {1'b0, cnt} + {15'd0, inc};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

    logic [31:0]            cfg_regs [NUM_REGS];
    logic [15:0]            err_cnt;
    logic                   cmd_err;

    logic [31:0]            wr_addr;
    logic [31:0]            wr_data;
    logic [ADDR_WIDTH-1:0]  wr_idx;
    logic                   wr_match, wr_in_range, wr_reg, wr_clr, wr_err;
    logic [31:0]            rd_addr;
    logic                   rd_match, rd_in_range, rd_err;
    logic [1:0]             err_inc;

    logic                   rd_vld_p0;
    logic [31:0]            rd_addr_p0;
    logic                   rd_oor_p0;
    logic [ADDR_WIDTH-1:0]  rd_idx_p0;
    logic [31:0]            rd_data_p0;

    logic                   ack_vld_p1;
    logic [203:0]           ack_p1;

    always_comb begin
        wr_addr     = bus.iv_wr_command[191:160];
        wr_data     = bus.iv_wr_command[31:0];
        wr_idx      = wr_addr[ADDR_WIDTH-1:0];
        wr_match    = bus.i_wr_command_wr && (bus.iv_wr_command[203:200] == TYPE_WR)
                      && (bus.iv_wr_command[199:192] == MODULE_ID);
        wr_in_range = (wr_addr >> ADDR_WIDTH) == 32'd0;
        wr_reg      = wr_match && wr_in_range && (wr_idx != ERR_ADDR);
        wr_clr      = wr_match && wr_in_range && (wr_idx == ERR_ADDR);
        wr_err      = wr_match && !wr_in_range;

        rd_addr     = bus.iv_rd_command[191:160];
        rd_match    = bus.i_rd_command_wr && (bus.iv_rd_command[203:200] == TYPE_RD)
                      && (bus.iv_rd_command[199:192] == MODULE_ID);
        rd_in_range = (rd_addr >> ADDR_WIDTH) == 32'd0;
        rd_err      = rd_match && !rd_in_range;

        err_inc     = {1'b0, wr_err} + {1'b0, rd_err};
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int k = 0; k < NUM_REGS; k++) cfg_regs[k] <= RST_VAL;
        end else begin
            for (int k = 0; k < NUM_REGS; k++)
                if (wr_reg && (wr_idx == ADDR_WIDTH'(k))) cfg_regs[k] <= wr_data;
        end
    end

    // Clear has priority over any error counted in the same cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            err_cnt <= 16'd0;
            cmd_err <= 1'b0;
        end else begin
            err_cnt <= wr_clr ? 16'd0 : sat_add(err_cnt, err_inc);
            cmd_err <= wr_err || rd_err;
        end
    end

    // Stage p0: capture read address, range flag and valid
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) rd_vld_p0 <= 1'b0;
        else       rd_vld_p0 <= rd_match;
    end

    always_ff @(posedge i_clk) begin
        if (rd_match) begin
            rd_addr_p0 <= rd_addr;
            rd_oor_p0  <= !rd_in_range;
        end
    end

    // Stage p1: the mux sees register state after the write edge of the strobe cycle
    always_comb begin
        rd_idx_p0  = rd_addr_p0[ADDR_WIDTH-1:0];
        rd_data_p0 = 32'd0;
        if (!rd_oor_p0) begin
            if (rd_idx_p0 == ERR_ADDR) begin
                rd_data_p0 = {16'd0, err_cnt};
            end else begin
                for (int k = 0; k < NUM_REGS; k++)
                    if (rd_idx_p0 == ADDR_WIDTH'(k)) rd_data_p0 = cfg_regs[k];
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ack_vld_p1 <= 1'b0;
            ack_p1     <= 204'd0;
        end else begin
            ack_vld_p1 <= rd_vld_p0;
            if (rd_vld_p0)
                ack_p1 <= {TYPE_ACK, MODULE_ID, rd_addr_p0, rd_oor_p0, 127'd0, rd_data_p0};
        end
    end

    assign bus.ov_rd_command_ack   = ack_p1;
    assign bus.o_rd_command_ack_wr = ack_vld_p1;
    assign bus.o_cmd_err           = cmd_err;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_cfg_out
        assign bus.ov_cfg_regs[32*g +: 32] = cfg_regs[g];
    end
endmodule

// File: tb/tb_cmd_reg_responder.sv
// Scoreboard bench for cmd_reg_responder: the driver queues expected acks and error
// pulses with their due cycle; a negedge monitor pops and compares what the DUT presents.
module tb_cmd_reg_responder;
    localparam int AW = 4;
    localparam int NUM_REGS = (1 << AW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    typedef struct {
        logic [203:0] ack;
        int           cyc;
    } ack_exp_t;

    ack_exp_t ack_q[$];
    int       err_q[$];

    cmd_reg_responder_if #(.ADDR_WIDTH(AW)) bus ();

    cmd_reg_responder #(
        .MODULE_ID (8'h05),
        .ADDR_WIDTH(AW),
        .RST_VAL   (32'd0)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    always #4 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compares every ack strobe and error pulse against the queues
    always @(negedge clk) begin
        ack_exp_t a;
        int       ec;
        if (bus.o_rd_command_ack_wr) begin
            n_checks++;
            if (ack_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_ack: got %h at cycle %0d, none expected", bus.ov_rd_command_ack, cyc);
            end else begin
                a = ack_q.pop_front();
                if (bus.ov_rd_command_ack !== a.ack || cyc != a.cyc) begin
                    n_fail++;
                    $display("FAIL ack: got %h at cycle %0d expected %h at cycle %0d",
                             bus.ov_rd_command_ack, cyc, a.ack, a.cyc);
                end
            end
        end else if (ack_q.size() > 0 && ack_q[0].cyc <= cyc) begin
            a = ack_q.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL missing_ack: got none at cycle %0d expected %h", cyc, a.ack);
        end

        if (bus.o_cmd_err) begin
            n_checks++;
            if (err_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_err: got pulse at cycle %0d, none expected", cyc);
            end else begin
                ec = err_q.pop_front();
                if (ec != cyc) begin
                    n_fail++;
                    $display("FAIL err_cycle: got pulse at cycle %0d expected cycle %0d", cyc, ec);
                end
            end
        end else if (err_q.size() > 0 && err_q[0] <= cyc) begin
            ec = err_q.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL missing_err: got no pulse expected one at cycle %0d", ec);
        end
    end

    function automatic logic [203:0] mk(input logic [3:0] t, input logic [7:0] id,
                                         input logic [31:0] a, input logic [31:0] d);
        return {t, id, a, 128'd0, d};
    endfunction

    task automatic drive(input logic wv, input logic [203:0] wc, input logic rv, input logic [203:0] rc);
        @(negedge clk);
        bus.i_wr_command_wr = wv;
        bus.iv_wr_command   = wc;
        bus.i_rd_command_wr = rv;
        bus.iv_rd_command   = rc;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 204'd0, 1'b0, 204'd0);
    endtask

    task automatic wr(input logic [7:0] id, input logic [31:0] a, input logic [31:0] d);
        drive(1'b1, mk(4'h1, id, a, d), 1'b0, 204'd0);
    endtask

    task automatic rd(input logic [7:0] id, input logic [31:0] a);
        drive(1'b0, 204'd0, 1'b1, mk(4'h2, id, a, 32'd0));
    endtask

    task automatic exp_ack(input logic [31:0] a, input logic e, input logic [31:0] d);
        ack_exp_t x;
        x.ack = {4'h3, 8'h05, a, e, 127'd0, d};
        x.cyc = cyc + 2;
        ack_q.push_back(x);
    endtask

    task automatic exp_err();
        err_q.push_back(cyc + 1);
    endtask

    logic [31:0] exp_vals [8];

    initial begin
        bus.i_wr_command_wr = 1'b0;
        bus.iv_wr_command   = 204'd0;
        bus.i_rd_command_wr = 1'b0;
        bus.iv_rd_command   = 204'd0;

        // Reset state
        idle(2);
        check("rst_ack_wr", {255'd0, bus.o_rd_command_ack_wr}, 256'd0);
        check("rst_ack", {52'd0, bus.ov_rd_command_ack}, 256'd0);
        check("rst_cmd_err", {255'd0, bus.o_cmd_err}, 256'd0);
        check("rst_cfg_lo", {32'd0, bus.ov_cfg_regs[223:0]}, 256'd0);
        check("rst_cfg_hi", {32'd0, bus.ov_cfg_regs[479:256]}, 256'd0);
        @(negedge clk) rst = 1'b0;
        idle(2);

        // Basic write then read with 2-cycle ack
        wr(8'h05, 32'd3, 32'hA5A5_0001);
        idle(1);
        check("wr_visible_reg3", {224'd0, bus.ov_cfg_regs[127:96]}, {224'd0, 32'hA5A5_0001});
        rd(8'h05, 32'd3); exp_ack(32'd3, 1'b0, 32'hA5A5_0001);
        idle(3);

        // Foreign id and wrong type are ignored
        wr(8'h06, 32'd4, 32'hDEAD_BEEF);
        rd(8'h06, 32'd3);
        drive(1'b1, mk(4'h2, 8'h05, 32'd5, 32'h0BAD_0BAD), 1'b0, 204'd0);
        drive(1'b0, 204'd0, 1'b1, mk(4'h1, 8'h05, 32'd3, 32'd0));
        idle(3);
        check("foreign_no_wr4", {224'd0, bus.ov_cfg_regs[159:128]}, 256'd0);
        check("wrongtype_no_wr5", {224'd0, bus.ov_cfg_regs[191:160]}, 256'd0);
        check("foreign_reg3_kept", {224'd0, bus.ov_cfg_regs[127:96]}, {224'd0, 32'hA5A5_0001});
        rd(8'h05, 32'd15); exp_ack(32'd15, 1'b0, 32'd0);
        idle(3);

        // Out-of-range write and read
        wr(8'h05, 32'h20, 32'h1111_1111); exp_err();
        rd(8'h05, 32'h10); exp_err(); exp_ack(32'h10, 1'b1, 32'd0);
        rd(8'h05, 32'd15); exp_ack(32'd15, 1'b0, 32'd2);
        idle(3);

        // Double error in one cycle: single pulse, counter +2
        drive(1'b1, mk(4'h1, 8'h05, 32'h8000_0000, 32'd1), 1'b1, mk(4'h2, 8'h05, 32'h40, 32'd0));
        exp_err(); exp_ack(32'h40, 1'b1, 32'd0);
        rd(8'h05, 32'd15); exp_ack(32'd15, 1'b0, 32'd4);
        idle(3);

        // Same-cycle write and read of addr 7, highest writable reg 14
        drive(1'b1, mk(4'h1, 8'h05, 32'd7, 32'h1234_5678), 1'b1, mk(4'h2, 8'h05, 32'd7, 32'd0));
        exp_ack(32'd7, 1'b0, 32'h1234_5678);
        wr(8'h05, 32'd14, 32'hCAFE_F00D);
        rd(8'h05, 32'd14); exp_ack(32'd14, 1'b0, 32'hCAFE_F00D);
        idle(1);
        check("reg14_visible", {224'd0, bus.ov_cfg_regs[479:448]}, {224'd0, 32'hCAFE_F00D});

        // Back-to-back reads 0..7
        exp_vals = '{32'd0, 32'd0, 32'd0, 32'hA5A5_0001, 32'd0, 32'd0, 32'd0, 32'h1234_5678};
        for (int i = 0; i < 8; i++) begin
            rd(8'h05, i);
            exp_ack(i, 1'b0, exp_vals[i]);
        end
        idle(3);

        // Saturation of the error counter
        for (int i = 0; i < 65540; i++) begin
            wr(8'h05, 32'h100, 32'd0);
            exp_err();
        end
        rd(8'h05, 32'd15); exp_ack(32'd15, 1'b0, 32'h0000_FFFF);
        idle(3);
        wr(8'h05, 32'd15, 32'hFFFF_FFFF);
        rd(8'h05, 32'd15); exp_ack(32'd15, 1'b0, 32'd0);
        idle(3);

        // Clear wins over a simultaneous error
        wr(8'h05, 32'h100, 32'd0); exp_err();
        drive(1'b1, mk(4'h1, 8'h05, 32'd15, 32'd0), 1'b1, mk(4'h2, 8'h05, 32'h100, 32'd0));
        exp_err(); exp_ack(32'h100, 1'b1, 32'd0);
        rd(8'h05, 32'd15); exp_ack(32'd15, 1'b0, 32'd0);
        idle(3);

        // Read of ERR_ADDR in the same cycle as its clear
        wr(8'h05, 32'h200, 32'd0); exp_err();
        drive(1'b1, mk(4'h1, 8'h05, 32'd15, 32'd0), 1'b1, mk(4'h2, 8'h05, 32'd15, 32'd0));
        exp_ack(32'd15, 1'b0, 32'd0);
        idle(3);

        // Reset with a read in flight: no ack afterwards, registers back to reset value
        wr(8'h05, 32'd2, 32'h5555_AAAA);
        rd(8'h05, 32'd2);
        @(negedge clk);
        bus.i_rd_command_wr = 1'b0;
        bus.i_wr_command_wr = 1'b0;
        rst = 1'b1;
        idle(2);
        @(negedge clk) rst = 1'b0;
        idle(4);
        check("post_rst_cfg_lo", {32'd0, bus.ov_cfg_regs[223:0]}, 256'd0);
        check("post_rst_cfg_hi", {32'd0, bus.ov_cfg_regs[479:256]}, 256'd0);
        check("post_rst_ack", {52'd0, bus.ov_rd_command_ack}, 256'd0);
        for (int i = 0; i < 16; i++) begin
            rd(8'h05, i);
            exp_ack(i, 1'b0, 32'd0);
        end
        idle(5);

        check("ack_queue_drained", 256'(ack_q.size()), 256'd0);
        check("err_queue_drained", 256'(err_q.size()), 256'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
